// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the iterative divider: FSM state encodings,
// default operand width and derived widths.
package div_ctrl_pkg;

   localparam int DIV_DATA_W   = 32;
   localparam int DIV_RESULT_W = 2 * DIV_DATA_W;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_ZERO = 2'b01,
      DIV_ON   = 2'b10,
      DIV_END  = 2'b11
   } div_state_e;

   // Iteration counter width for a given operand width.
   function automatic int div_cnt_w(input int data_w);
      return $clog2(data_w) + 1;
   endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (purely combinational).
// Shifts the next dividend bit into the partial remainder, trial-subtracts
// the divisor and keeps the difference only when it is non-negative.
module div_step
   import div_ctrl_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W
) (
   input  logic [DATA_W-1:0] rem_in,
   input  logic              dvd_bit,
   input  logic [DATA_W-1:0] dvs,
   output logic [DATA_W-1:0] rem_out,
   output logic              quo_bit
);

   logic [DATA_W:0] shifted;
   logic [DATA_W:0] diff;

   assign shifted = {rem_in, dvd_bit};
   assign diff    = shifted - {1'b0, dvs};

   // A clear borrow bit means the divisor fits: keep the difference.
   // Otherwise the shifted remainder is below the divisor, so it still
   // fits in DATA_W bits and is kept as is.
   assign quo_bit = ~diff[DATA_W];
   assign rem_out = quo_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];

endmodule

// File: rtl/div_ctrl.sv
// EX-stage DIV/DIVU sequencer: one restoring step per cycle, with sign
// fix-up applied as the result is loaded into END.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor takes a one-cycle
// ZERO detour and returns {0, 0} instead of running the full iteration.
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                signed_div,
   input  logic [DATA_W-1:0]   opdata1,
   input  logic [DATA_W-1:0]   opdata2,
   input  logic                annul,
   output logic [2*DATA_W-1:0] result,
   output logic                ready,
   output logic                stallreq
);

   localparam int              CNT_W    = div_cnt_w(DATA_W);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   div_state_e          state_reg, state_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [DATA_W-1:0]   rem_reg, rem_next;
   logic [DATA_W-1:0]   quo_reg, quo_next;      // dividend bits shift out, quotient bits shift in
   logic [DATA_W-1:0]   dvs_reg, dvs_next;
   logic                neg_quo_reg, neg_quo_next;
   logic                neg_rem_reg, neg_rem_next;
   logic [2*DATA_W-1:0] result_reg, result_next;

   logic [DATA_W-1:0]   step_rem;
   logic                step_q;
   logic [DATA_W-1:0]   fin_quo;
   logic [DATA_W-1:0]   op1_mag;
   logic [DATA_W-1:0]   op2_mag;

   function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
      return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
   endfunction

   div_step #(.DATA_W(DATA_W)) u_step (
      .rem_in  (rem_reg),
      .dvd_bit (quo_reg[DATA_W-1]),
      .dvs     (dvs_reg),
      .rem_out (step_rem),
      .quo_bit (step_q)
   );

   // Magnitudes for signed ops; the most negative value maps to 2^(W-1) unsigned.
   assign op1_mag = (signed_div && opdata1[DATA_W-1]) ? negate(opdata1) : opdata1;
   assign op2_mag = (signed_div && opdata2[DATA_W-1]) ? negate(opdata2) : opdata2;
   assign fin_quo = {quo_reg[DATA_W-2:0], step_q};
   assign result  = result_reg;

   // State and datapath registers, cleared immediately by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= DIV_IDLE;
         cnt_reg     <= '0;
         rem_reg     <= '0;
         quo_reg     <= '0;
         dvs_reg     <= '0;
         neg_quo_reg <= 1'b0;
         neg_rem_reg <= 1'b0;
         result_reg  <= '0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         rem_reg     <= rem_next;
         quo_reg     <= quo_next;
         dvs_reg     <= dvs_next;
         neg_quo_reg <= neg_quo_next;
         neg_rem_reg <= neg_rem_next;
         result_reg  <= result_next;
      end
   end

   // Next-state, datapath update and handshake outputs.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      rem_next     = rem_reg;
      quo_next     = quo_reg;
      dvs_next     = dvs_reg;
      neg_quo_next = neg_quo_reg;
      neg_rem_next = neg_rem_reg;
      result_next  = result_reg;
      ready        = 1'b0;
      stallreq     = 1'b0;

      case (state_reg)
         DIV_IDLE: begin
            result_next = '0;
            cnt_next    = '0;
            if (start && !annul) begin
               stallreq     = 1'b1;
               rem_next     = '0;
               quo_next     = op1_mag;
               dvs_next     = op2_mag;
               neg_quo_next = signed_div & (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
               neg_rem_next = signed_div & opdata1[DATA_W-1];
`ifdef DIV_ZERO_FAST_EN
               if (opdata2 == '0) state_next = DIV_ZERO;
               else               state_next = DIV_ON;
`else
               state_next = DIV_ON;
`endif
            end
         end

         DIV_ZERO: begin
            stallreq = 1'b1;
            if (annul) begin
               state_next = DIV_IDLE;
            end else begin
               state_next  = DIV_END;
               result_next = '0;
            end
         end

         DIV_ON: begin
            stallreq = 1'b1;
            if (annul) begin
               state_next = DIV_IDLE;
            end else begin
               rem_next = step_rem;
               quo_next = fin_quo;
               cnt_next = cnt_reg + CNT_W'(1);
               if (cnt_reg == LAST_CNT) begin
                  state_next  = DIV_END;
                  result_next = {neg_rem_reg ? negate(step_rem) : step_rem,
                                 neg_quo_reg ? negate(fin_quo)  : fin_quo};
               end
            end
         end

         DIV_END: begin
            ready = 1'b1;
            if (!start) begin
               state_next  = DIV_IDLE;
               result_next = '0;
            end
         end

         default: begin
            state_next = DIV_IDLE;
         end
      endcase
   end

endmodule
